switch_egress_arbiter: RTL

//  Responder side of the switch egress request handshake. Each per-port requester raises in_tvalid
//  to request the switch and treats in_tready as its grant. This block arbitrates NUM_PORTS

---
 rtl/switch_egress_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/switch_egress_arbiter.sv
// Switch egress arbiter: round-robin grant over NUM_PORTS AXI-Stream requesters,
// grant locked for a whole frame, oversize frames truncated (forced tlast) with
// the remainder drained, and saturating frame statistics.
module switch_egress_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BEATS  = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_PORTS-1:0]            in_tvalid,
    input  logic [NUM_PORTS-1:0]            in_tlast,
    output logic [NUM_PORTS-1:0]            in_tready,
    output logic [DATA_WIDTH-1:0]           out_tdata,
    output logic                            out_tvalid,
    output logic                            out_tlast,
    input  logic                            out_tready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            frames_fwd,
    output logic [CNT_WIDTH-1:0]            frames_trunc
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [GW-1:0]    rr_ptr_q;
    logic [GW-1:0]    grant_id_q;
    logic [BW-1:0]    beat_cnt_q;
    logic [CNT_WIDTH-1:0] frames_fwd_q;
    logic [CNT_WIDTH-1:0] frames_trunc_q;

    logic [GW-1:0]    rr_ptr_d;
    logic [CNT_WIDTH-1:0] frames_fwd_d;
    logic [CNT_WIDTH-1:0] frames_trunc_d;

    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic [GW-1:0]    cand;
    logic             g_valid;
    logic             g_last;
    logic             at_limit;
    logic             out_hs;

    // Split the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = in_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign g_valid  = in_tvalid[grant_id_q];
    assign g_last   = in_tlast[grant_id_q];
    assign at_limit = (beat_cnt_q == LAST_BEAT);
    assign out_hs   = out_tvalid & out_tready;

    // Round-robin pick: first requesting port at or after rr_ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (in_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next pointer after a frame, and saturating counter increments.
    always_comb begin
        rr_ptr_d       = (grant_id_q == GW'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
        frames_fwd_d   = (frames_fwd_q == '1) ? frames_fwd_q : frames_fwd_q + 1'b1;
        frames_trunc_d = (frames_trunc_q == '1) ? frames_trunc_q : frames_trunc_q + 1'b1;
    end

    // Forwarding path driven from the registered grant; quiet outside PASS/DRAIN.
    always_comb begin
        in_tready  = '0;
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        case (state_q)
            PASS: begin
                out_tdata             = port_data[grant_id_q];
                out_tvalid            = g_valid;
                out_tlast             = g_last | at_limit;
                in_tready[grant_id_q] = out_tready;
            end
            DRAIN: begin
                in_tready[grant_id_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Arbitration FSM, beat counting and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            beat_cnt_q     <= '0;
            frames_fwd_q   <= '0;
            frames_trunc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id_q <= pick_idx;
                        state_q    <= PASS;
                    end
                end
                PASS: begin
                    if (out_hs) begin
                        if (g_last) begin
                            // A genuine last wins even on the truncation boundary.
                            frames_fwd_q <= frames_fwd_d;
                            rr_ptr_q     <= rr_ptr_d;
                            beat_cnt_q   <= '0;
                            state_q      <= IDLE;
                        end else if (at_limit) begin
                            frames_fwd_q   <= frames_fwd_d;
                            frames_trunc_q <= frames_trunc_d;
                            state_q        <= DRAIN;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        rr_ptr_q   <= rr_ptr_d;
                        beat_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_id     = grant_id_q;
    assign busy         = (state_q != IDLE);
    assign frames_fwd   = frames_fwd_q;
    assign frames_trunc = frames_trunc_q;

endmodule
